// File: rtl/psum_acc_act.sv
// psum_acc_act: row-wise partial-sum accumulator with bias add, saturation and activation.
//
// Accumulates CIN channel passes of ROW_LEN signed partial sums into an on-chip row buffer.
// After the last channel pass it drains the row: each entry gets the bias added, is
// saturated to DW bits, goes through the activation and leaves via a valid/ready port.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   psum_i/psum_valid/     partial-sum input stream (accepted only while accumulating)
//   psum_ready
//   bias_i/bias_load       per-output-channel bias, captured only while accumulating
//   data_o/valid_o/ready_i activated result stream
//   row_done               one-cycle pulse on the last output handshake of a row
//
// Build option: define PSUM_ACC_RELU_EN to clamp negative results to zero (ReLU).
// Without it the saturated result passes through unchanged.
module psum_acc_act #(
  parameter int unsigned DW      = 32,
  parameter int unsigned FW      = 8,
  parameter int unsigned ROW_LEN = 56,
  parameter int unsigned CIN     = 64,
  parameter int unsigned ACC_W   = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] psum_i,
  input  logic          psum_valid,
  output logic          psum_ready,
  input  logic [DW-1:0] bias_i,
  input  logic          bias_load,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          row_done
);

  localparam int unsigned PW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned CW = (CIN > 1) ? $clog2(CIN) : 1;
  localparam logic [PW-1:0] PLast = PW'(ROW_LEN - 1);
  localparam logic [CW-1:0] CLast = CW'(CIN - 1);
  // Partial sums and bias share the same fixed-point format, so no alignment shift.
  localparam int unsigned BiasShift = FW - FW;

  typedef enum logic [0:0] {StAcc, StDrain} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] c_q, c_d;
  logic [PW-1:0] q_q, q_d;
  logic [DW-1:0] bias_q, bias_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  // Row buffer; no reset needed since the first channel pass overwrites every entry.
  logic [ACC_W-1:0] acc_mem_q [ROW_LEN];

  // Accumulate path
  logic             acc_we;
  logic [ACC_W-1:0] psum_ext;
  logic [ACC_W-1:0] acc_old;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_wr;

  assign psum_ready = (state_q == StAcc);
  assign acc_we     = psum_valid && psum_ready;
  assign psum_ext   = ACC_W'($signed(psum_i));
  assign acc_old    = acc_mem_q[p_q];

  always_comb begin
    if (c_q == '0) begin
      acc_sum = {psum_ext[ACC_W-1], psum_ext};
    end else begin
      acc_sum = {acc_old[ACC_W-1], acc_old} + {psum_ext[ACC_W-1], psum_ext};
    end
    // Overflow when the two top bits of the widened sum disagree.
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_wr = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_wr = acc_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_mem_q[p_q] <= acc_wr;
    end
  end

  // Drain path: ld_idx is the entry loaded into data_o this cycle (if a load happens).
  logic [PW-1:0]  ld_idx;
  logic [ACC_W-1:0] rd_val;
  logic [ACC_W:0] bias_ext;
  logic [ACC_W:0] res_sum;
  logic           res_fits;
  logic [DW-1:0]  res_sat;
  logic [DW-1:0]  res_act;

  assign ld_idx   = (valid_q && (q_q != PLast)) ? q_q + PW'(1) : q_q;
  assign rd_val   = acc_mem_q[ld_idx];
  assign bias_ext = (ACC_W + 1)'($signed(bias_q));
  assign res_sum  = (ACC_W + 1)'($signed(rd_val)) + (bias_ext <<< BiasShift);
  // Fits in DW when every bit from the DW sign bit upward matches.
  assign res_fits = (&res_sum[ACC_W:DW-1]) || !(|res_sum[ACC_W:DW-1]);

  always_comb begin
    if (res_fits) begin
      res_sat = res_sum[DW-1:0];
    end else begin
      res_sat = res_sum[ACC_W] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`ifdef PSUM_ACC_RELU_EN
    res_act = res_sat[DW-1] ? '0 : res_sat;
`else
    res_act = res_sat;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    q_d     = q_q;
    bias_d  = bias_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StAcc: begin
        if (bias_load) begin
          bias_d = bias_i;
        end
        if (acc_we) begin
          if (p_q == PLast) begin
            p_d = '0;
            if (c_q == CLast) begin
              c_d     = '0;
              state_d = StDrain;
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            p_d = p_q + PW'(1);
          end
        end
      end
      StDrain: begin
        // Load a new result when the output slot is empty or being consumed.
        if (!valid_q || ready_i) begin
          if (valid_q && (q_q == PLast)) begin
            valid_d = 1'b0;
            q_d     = '0;
            state_d = StAcc;
          end else begin
            data_d  = res_act;
            valid_d = 1'b1;
            if (valid_q) begin
              q_d = q_q + PW'(1);
            end
          end
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      p_q     <= '0;
      c_q     <= '0;
      q_q     <= '0;
      bias_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      q_q     <= q_d;
      bias_q  <= bias_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign row_done = (state_q == StDrain) && valid_q && ready_i && (q_q == PLast);

endmodule

// File: tb/tb_psum_acc_act.sv
// Directed self-checking bench for psum_acc_act (ROW_LEN=4, CIN=2, DW=32, ACC_W=40).
module tb_psum_acc_act;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] psum_i;
  logic          psum_valid;
  logic          psum_ready;
  logic [DW-1:0] bias_i;
  logic          bias_load;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          row_done;

  int tests_run;
  int tests_failed;

  logic [DW-1:0] vec  [8];
  logic [DW-1:0] exp4 [4];

  psum_acc_act #(
    .DW     (32),
    .FW     (8),
    .ROW_LEN(4),
    .CIN    (2),
    .ACC_W  (40)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psum_i    (psum_i),
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .bias_i    (bias_i),
    .bias_load (bias_load),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .row_done  (row_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bias(input logic [DW-1:0] b);
    bias_i    = b;
    bias_load = 1'b1;
    step();
    bias_load = 1'b0;
  endtask

  // Feeds vec[0..3] as channel 0 and vec[4..7] as channel 1, one per cycle.
  task automatic feed_row();
    for (int i = 0; i < 8; i++) begin
      psum_i     = vec[i];
      psum_valid = 1'b1;
      step();
    end
    psum_valid = 1'b0;
    psum_i     = '0;
  endtask

  // Waits (bounded) for valid_o, then drains all four results against exp4.
  task automatic drain_check(input string name);
    ready_i = 1'b1;
    for (int i = 0; i < 8 && !valid_o; i++) step();
    tests_run++;
    if (valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s timeout: valid_o=%b required 1", name, valid_o);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (valid_o !== 1'b1 || data_o !== exp4[k] || row_done !== (k == 3)) begin
        tests_failed++;
        $display("FAIL %s q=%0d: valid=%b data=%h row_done=%b required valid=1 data=%h row_done=%b",
                 name, k, valid_o, data_o, row_done, exp4[k], (k == 3));
      end
      step();
    end
    tests_run++;
    if (valid_o !== 1'b0 || psum_ready !== 1'b1 || row_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s end: valid=%b psum_ready=%b row_done=%b required 0 1 0",
               name, valid_o, psum_ready, row_done);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    psum_i     = '0;
    psum_valid = 1'b0;
    bias_i     = '0;
    bias_load  = 1'b0;
    ready_i    = 1'b0;
    step();
    step();
    tests_run++;
    if (valid_o !== 1'b0 || data_o !== '0 || row_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b data=%h row_done=%b required 0 0 0",
               valid_o, data_o, row_done);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (psum_ready !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: psum_ready=%b valid=%b required 1 0", psum_ready, valid_o);
    end
  endtask

  task automatic test_basic();
    load_bias(32'h100);
    vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40};
    feed_row();
    // Just entered drain: nothing presented yet, input closed.
    tests_run++;
    if (valid_o !== 1'b0 || psum_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_enter_drain: valid=%b psum_ready=%b required 0 0", valid_o, psum_ready);
    end
    ready_i = 1'b1;
    step();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 32'h10B) begin
      tests_failed++;
      $display("FAIL basic_latency: valid=%b data=%h required 1 0000010b", valid_o, data_o);
    end
    exp4 = '{32'h10B, 32'h116, 32'h121, 32'h12C};
    drain_check("basic");
  endtask

  task automatic test_negative();
    load_bias(32'h0);
    vec = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB,
            32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    feed_row();
`ifdef PSUM_ACC_RELU_EN
    exp4 = '{32'h0, 32'h0, 32'h0, 32'h0};
`else
    exp4 = '{32'hFFFF_FFF6, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 32'hFFFF_FFF6};
`endif
    drain_check("negative");
  endtask

  task automatic test_saturation();
    load_bias(32'h7FFF_FFFF);
    for (int i = 0; i < 8; i++) vec[i] = 32'h7FFF_FFFF;
    feed_row();
    exp4 = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    drain_check("saturation");
    // Negative side: large negative sums clamp to the DW minimum (ReLU turns that into 0).
    load_bias(32'h8000_0000);
    for (int i = 0; i < 8; i++) vec[i] = 32'h8000_0000;
    feed_row();
`ifdef PSUM_ACC_RELU_EN
    exp4 = '{32'h0, 32'h0, 32'h0, 32'h0};
`else
    exp4 = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
`endif
    drain_check("saturation_neg");
  endtask

  task automatic test_backpressure();
    load_bias(32'h0);
    ready_i = 1'b0;
    vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4};
    feed_row();
    step();
    for (int i = 0; i < 5; i++) begin
      psum_i     = 32'h55;
      psum_valid = (i % 2 == 0);
      tests_run++;
      if (valid_o !== 1'b1 || data_o !== 32'd2 || psum_ready !== 1'b0 || row_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold cyc=%0d: valid=%b data=%h psum_ready=%b row_done=%b required 1 00000002 0 0",
                 i, valid_o, data_o, psum_ready, row_done);
      end
      step();
    end
    psum_valid = 1'b0;
    psum_i     = '0;
    exp4 = '{32'd2, 32'd4, 32'd6, 32'd8};
    drain_check("backpressure");
    // Any psum wrongly accepted above would misalign this row.
    vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40};
    feed_row();
    exp4 = '{32'd11, 32'd22, 32'd33, 32'd44};
    drain_check("after_backpressure");
  endtask

  task automatic test_reset_mid_row();
    load_bias(32'h55);
    for (int i = 0; i < 3; i++) begin
      psum_i     = 32'h1000;
      psum_valid = 1'b1;
      step();
    end
    psum_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    tests_run++;
    if (valid_o !== 1'b0 || data_o !== '0 || psum_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%b data=%h psum_ready=%b required 0 0 1",
               valid_o, data_o, psum_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (psum_ready !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_release: psum_ready=%b valid=%b required 1 0", psum_ready, valid_o);
    end
    // Bias was cleared by reset, stale buffer entries must be overwritten.
    vec = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    feed_row();
    exp4 = '{32'd6, 32'd8, 32'd10, 32'd12};
    drain_check("reset_mid_row");
  endtask

  task automatic test_bias_in_drain();
    load_bias(32'h20);
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) vec[i] = 32'd1;
    feed_row();
    bias_i    = 32'h999;
    bias_load = 1'b1;
    step();
    step();
    bias_load = 1'b0;
    exp4 = '{32'h22, 32'h22, 32'h22, 32'h22};
    drain_check("bias_in_drain");
    feed_row();
    drain_check("bias_next_row");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_reset_mid_row();
    test_bias_in_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/psum_acc_act.md
PSUM_ACC_ACT -- requirements
Module: psum_acc_act

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter FW, default 8, fractional bits of the fixed-point format (IW = DW-FW integer bits).
REQ-003 SHALL have parameter ROW_LEN, default 56, outputs per feature-map row.
REQ-004 SHALL have parameter CIN, default 64, input channels accumulated per row.
REQ-005 SHALL have parameter ACC_W, default 40, accumulator width, ACC_W >= DW.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port psum_i, input, DW, signed partial sum from the PE array.
REQ-009 SHALL have port psum_valid, input, 1, psum_i valid.
REQ-010 SHALL have port psum_ready, output, 1, block accepts psum_i.
REQ-011 SHALL have port bias_i, input, DW, signed per-output-channel bias.
REQ-012 SHALL have port bias_load, input, 1, capture bias_i.
REQ-013 SHALL have port data_o, output, DW, signed activated result.
REQ-014 SHALL have port valid_o, output, 1, data_o valid.
REQ-015 SHALL have port ready_i, input, 1, consumer accepts data_o.
REQ-016 SHALL have port row_done, output, 1, one-cycle pulse on the last output handshake of a row.

Function
REQ-017 SHALL implement two states, ACC and DRAIN, and enter ACC after reset.
REQ-018 SHALL assert psum_ready only in ACC and SHALL accept a partial sum only on psum_valid && psum_ready.
REQ-019 SHALL track position counter p (0..ROW_LEN-1) and channel counter c (0..CIN-1); each accepted partial sum increments p, and p wrapping from ROW_LEN-1 to 0 increments c.
REQ-020 SHALL sign-extend psum_i to ACC_W and write it to buf[p] when c==0; when c>0 it SHALL write buf[p]+psum_i, saturated to the signed ACC_W range.
REQ-021 SHALL move to DRAIN on the accept where p==ROW_LEN-1 and c==CIN-1, clearing p and c.
REQ-022 In DRAIN, SHALL compute r = buf[q] + (bias << 0, sign-extended), saturate r to the signed DW range, apply activation (REQ-034/035), and register the result into data_o.
REQ-023 SHALL raise valid_o exactly one cycle after entering DRAIN, holding data_o for q=0.
REQ-024 SHALL hold data_o and valid_o stable while valid_o && !ready_i.
REQ-025 SHALL advance q on each valid_o && ready_i handshake and present the next result in the following cycle, with no bubble when ready_i stays high.
REQ-026 On the handshake at q==ROW_LEN-1, SHALL pulse row_done, drop valid_o in the next cycle, and return to ACC.
REQ-027 SHALL capture bias_i on bias_load in ACC; bias_load in DRAIN SHALL be ignored, so the bias stays constant for a whole drain.
REQ-028 psum_valid during DRAIN SHALL have no effect (psum_ready=0).
REQ-029 Throughput SHALL be one partial sum per cycle in ACC and one output per cycle in DRAIN.

Reset
REQ-030 rst_n low SHALL asynchronously force state=ACC, p=c=q=0, bias=0, data_o=0, valid_o=0, row_done=0.
REQ-031 psum_ready SHALL be 1 from the first clock after reset release.
REQ-032 Reset mid-row or mid-drain SHALL discard the partial row; buf contents need not be cleared because c==0 overwrites them.
REQ-033 All state SHALL be clocked on clk only.

Configuration
REQ-034 With macro PSUM_ACC_RELU_EN defined, the activation SHALL be ReLU: a negative saturated result is output as 0.
REQ-035 Without PSUM_ACC_RELU_EN, the saturated result SHALL pass through unchanged, including negative values.

Verification (ROW_LEN=4, CIN=2, DW=32, ACC_W=40)
REQ-036 Reset, bias=0x100, then feed channel 0 {1,2,3,4} and channel 1 {10,20,30,40} -> outputs {0x10B,0x116,0x121,0x12C} with row_done on the 4th handshake.
REQ-037 With RELU_EN, bias=0, feed ch0 {-5,...} and ch1 {-5,...} -> output 0 at q=0; without RELU_EN -> 0xFFFFFFF6.
REQ-038 Feed ch0 = ch1 = 0x7FFFFFFF, bias=0x7FFFFFFF -> data_o = 0x7FFFFFFF (saturated).
REQ-039 Hold ready_i=0 for 5 cycles in DRAIN -> data_o and valid_o stable; psum_ready=0; psum_valid pulses are ignored.
REQ-040 Pulse rst_n low after 3 accepts -> valid_o=0 and psum_ready=1; a fresh full row then produces correct results unaffected by stale buf.
REQ-041 Apply bias_load with a new value during DRAIN -> the current row uses the old bias, and the next row also uses the old bias unless it is reloaded in ACC.
